intra_pred_sched: RTL
=====================

# intra_pred_sched

Sequencer for the 4x4 intra-prediction datapath. It accepts one TU command (size, mode, filter flag), runs the DC reference-accumulation phases when the mode is DC, then walks every 4x4 sub-block of the TU in raster order. Per sub-block it drives the datapath controls X, Y, preStage, unFil_opt and bStop, and presents each 16-sample result on a valid/ready output. It sits between the TU-level control FSM / reference fetcher and the prediction datapath.

## Interface
- No parameters (TU geometry fixed: 4x4 to 32x32).
- clk  in  1  clock.
- arst_n  in  1  asynchronous reset, active-low.
- rst_n  in  1  synchronous clear, active-low; same effect as arst_n on next edge.
- cmd_valid  in  1  TU command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_tuSize  in  3  0=4x4, 1=8x8, 2=16x16, 3=32x32; 4..7 illegal.
- cmd_mode  in  6  0=planar, 1=DC, 2..34 angular.
- cmd_filt  in  1  edge-filter enable.
- ref_valid  in  1  reference / DC partial sums for current step available.
- dp_X, dp_Y  out  3  sub-block column/row within TU.
- dp_preStage  out  4  DC accumulation phase; 4'b1000 = hold.
- dp_unFil_opt  out  2  0=use registered DC, 1=compute from stored sum, 2=compute from stored+current.
- dp_bStop  out  1  freezes datapath registers.
- dp_tuSize  out  3, dp_mode  out  6, dp_isPredFilter  out  1  latched command.
- out_valid  out  1  datapath result valid.
- out_ready  in  1  consumer accepts.
- out_last  out  1  qualifies final sub-block of TU.
- err  out  1  sticky illegal-size flag; cleared only by reset.

## Operation
- States: IDLE, ACC, SETTLE, PRED.
- IDLE: cmd_ready=1. On cmd_valid, latch command; tuSize>3 is clamped to 3 and sets err. Next state: ACC if mode==1, else PRED. X=Y=0 on entry.
- ACC phase count P: tu1 -> 2 phases; tu0, tu2, tu3 -> 1 phase.
- ACC: dp_preStage = phase index (0..P-1). dp_unFil_opt=2 on last phase, else 0.
- ACC phase advances only when ref_valid=1. After the last phase:
  - tu1, tu2, tu3 -> PRED.
  - tu0 -> SETTLE (phase 0 is load-only).
- SETTLE (tu0 DC only): one cycle, preStage=4'b1000, unFil_opt=1, no ref needed; then -> PRED.
- PRED: preStage=4'b1000, unFil_opt=0.
  - out_valid = ref_valid.
  - Transfer = out_valid & out_ready.
  - On transfer, X increments; X wraps to 0 at B-1 (B = 1<<tuSize, so B=1,2,4,8) and Y increments.
  - out_last = (X==B-1 && Y==B-1).
  - Transfer with out_last -> IDLE.
- dp_bStop:
  - ACC: !ref_valid.
  - SETTLE: 0.
  - PRED: !(ref_valid & out_ready).
  - IDLE: 1.
- Block counts: 1, 4, 16, 64 for tu0..tu3.

## Timing
- All outputs registered except cmd_ready, out_valid, out_last and dp_bStop, which are decoded from registered state plus ref_valid/out_ready.
- Reset values:
  - state=IDLE; X=Y=0; preStage=0; unFil_opt=0; latched cmd=0; err=0.
  - Hence cmd_ready=1, out_valid=0, out_last=0, dp_bStop=1.
- Command acceptance: PRED (non-DC) starts the cycle after acceptance. DC adds P cycles (plus 1 SETTLE for tu0), assuming ref_valid held high.
- Throughput: one sub-block per cycle with ref_valid=out_ready=1. There is one idle cycle between TUs, because cmd_ready is low in the cycle of the last transfer.
- out_ready low: X, Y and all dp_* outputs hold; out_valid stays high if ref_valid stays high. out_valid never drops without a transfer unless ref_valid drops.
- Reset (arst_n or rst_n) mid-TU aborts: IDLE next edge, no out_last, no partial counters retained.
- cmd_valid outside IDLE is ignored (no latch, no err update).

## Test plan
- tu0 planar, ref_valid=out_ready=1 -> accepted at t, out_valid at t+1 with X=Y=0, out_last=1, cmd_ready=1 at t+2.
- tu3 DC:
  - -> 1 ACC cycle (preStage=0, unFil_opt=2), then 64 transfers in raster order (X,Y)=(0,0),(1,0)..(7,7).
  - out_last only on (7,7); preStage=8 and unFil_opt=0 throughout PRED.
- tu1 DC with ref_valid low for 3 cycles in phase 1 -> preStage holds 1, bStop=1 for 3 cycles, unFil_opt=2 on the advancing cycle, then 4 blocks.
- tu0 DC -> ACC (preStage=0, unFil_opt=2), SETTLE (preStage=8, unFil_opt=1, bStop=0), then 1 block.
- tu2 angular with out_ready toggling 1,0,0,1… -> X/Y advance only on ready cycles, dp_bStop=1 while stalled, exactly 16 transfers.
- cmd_tuSize=5 -> err=1, runs as 32x32 (64 blocks).
- rst_n low at block 10 -> IDLE next cycle, cmd_ready=1, err retained until reset… err cleared by rst_n.

Source files
------------

// File: rtl/intra_pred_sched.sv
// Sub-block sequencer for the 4x4 intra-prediction datapath: accepts one TU command,
// runs the DC accumulation phases when needed, then walks all 4x4 sub-blocks in raster order.
module intra_pred_sched (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       rst_n_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [2:0] cmd_tuSize_i,
  input  logic [5:0] cmd_mode_i,
  input  logic       cmd_filt_i,
  input  logic       ref_valid_i,
  output logic [2:0] dp_X_o,
  output logic [2:0] dp_Y_o,
  output logic [3:0] dp_preStage_o,
  output logic [1:0] dp_unFil_opt_o,
  output logic       dp_bStop_o,
  output logic [2:0] dp_tuSize_o,
  output logic [5:0] dp_mode_o,
  output logic       dp_isPredFilter_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       out_last_o,
  output logic       err_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACC    = 2'd1,
    S_SETTLE = 2'd2,
    S_PRED   = 2'd3
  } state_e;

  localparam logic [3:0] PRE_HOLD = 4'b1000;
  localparam logic [5:0] MODE_DC  = 6'd1;
  localparam logic [1:0] UF_REG   = 2'd0;
  localparam logic [1:0] UF_STORE = 2'd1;
  localparam logic [1:0] UF_BOTH  = 2'd2;

  state_e     state_q, state_d;
  logic [2:0] x_q, x_d;
  logic [2:0] y_q, y_d;
  logic [3:0] pre_q, pre_d;
  logic [1:0] unf_q, unf_d;
  logic [2:0] tu_q, tu_d;
  logic [5:0] mode_q, mode_d;
  logic       filt_q, filt_d;
  logic       err_q, err_d;
  logic       phase_q, phase_d;

  logic [2:0] tu_eff;
  logic [2:0] b_max;
  logic       x_end;
  logic       y_end;
  logic       acc_last;
  logic       xfer;

  // Sizes 4..7 are clamped to 32x32.
  assign tu_eff = cmd_tuSize_i[2] ? 3'd3 : {1'b0, cmd_tuSize_i[1:0]};

  always_comb begin
    b_max = 3'd7;
    case (tu_q)
      3'd0:    b_max = 3'd0;
      3'd1:    b_max = 3'd1;
      3'd2:    b_max = 3'd3;
      default: b_max = 3'd7;
    endcase
  end

  assign x_end    = (x_q == b_max);
  assign y_end    = (y_q == b_max);
  // Only 8x8 needs two accumulation phases.
  assign acc_last = (tu_q == 3'd1) ? phase_q : 1'b1;
  assign xfer     = (state_q == S_PRED) && ref_valid_i && out_ready_i;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    pre_d       = pre_q;
    unf_d       = unf_q;
    tu_d        = tu_q;
    mode_d      = mode_q;
    filt_d      = filt_q;
    err_d       = err_q;
    phase_d     = phase_q;
    cmd_ready_o = 1'b0;
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    dp_bStop_o  = 1'b1;

    case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          tu_d    = tu_eff;
          mode_d  = cmd_mode_i;
          filt_d  = cmd_filt_i;
          x_d     = 3'd0;
          y_d     = 3'd0;
          phase_d = 1'b0;
          if (cmd_tuSize_i[2]) begin
            err_d = 1'b1;
          end
          if (cmd_mode_i == MODE_DC) begin
            state_d = S_ACC;
            pre_d   = 4'd0;
            unf_d   = (tu_eff == 3'd1) ? UF_REG : UF_BOTH;
          end else begin
            state_d = S_PRED;
            pre_d   = PRE_HOLD;
            unf_d   = UF_REG;
          end
        end
      end

      S_ACC: begin
        dp_bStop_o = !ref_valid_i;
        if (ref_valid_i) begin
          if (!acc_last) begin
            phase_d = 1'b1;
            pre_d   = 4'd1;
            unf_d   = UF_BOTH;
          end else if (tu_q == 3'd0) begin
            // 4x4 phase 0 only loads the sum; one extra cycle computes DC from it.
            state_d = S_SETTLE;
            pre_d   = PRE_HOLD;
            unf_d   = UF_STORE;
          end else begin
            state_d = S_PRED;
            pre_d   = PRE_HOLD;
            unf_d   = UF_REG;
          end
        end
      end

      S_SETTLE: begin
        dp_bStop_o = 1'b0;
        state_d    = S_PRED;
        pre_d      = PRE_HOLD;
        unf_d      = UF_REG;
      end

      S_PRED: begin
        out_valid_o = ref_valid_i;
        out_last_o  = x_end && y_end;
        dp_bStop_o  = !(ref_valid_i && out_ready_i);
        if (xfer) begin
          if (!x_end) begin
            x_d = x_q + 3'd1;
          end else begin
            x_d = 3'd0;
            if (y_end) begin
              state_d = S_IDLE;
              y_d     = 3'd0;
              pre_d   = 4'd0;
              unf_d   = UF_REG;
            end else begin
              y_d = y_q + 3'd1;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      x_q     <= 3'd0;
      y_q     <= 3'd0;
      pre_q   <= 4'd0;
      unf_q   <= 2'd0;
      tu_q    <= 3'd0;
      mode_q  <= 6'd0;
      filt_q  <= 1'b0;
      err_q   <= 1'b0;
      phase_q <= 1'b0;
    end else if (!rst_n_i) begin
      state_q <= S_IDLE;
      x_q     <= 3'd0;
      y_q     <= 3'd0;
      pre_q   <= 4'd0;
      unf_q   <= 2'd0;
      tu_q    <= 3'd0;
      mode_q  <= 6'd0;
      filt_q  <= 1'b0;
      err_q   <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pre_q   <= pre_d;
      unf_q   <= unf_d;
      tu_q    <= tu_d;
      mode_q  <= mode_d;
      filt_q  <= filt_d;
      err_q   <= err_d;
      phase_q <= phase_d;
    end
  end

  assign dp_X_o            = x_q;
  assign dp_Y_o            = y_q;
  assign dp_preStage_o     = pre_q;
  assign dp_unFil_opt_o    = unf_q;
  assign dp_tuSize_o       = tu_q;
  assign dp_mode_o         = mode_q;
  assign dp_isPredFilter_o = filt_q;
  assign err_o             = err_q;

endmodule
